// File: rtl/coalesce_splitter_queued_pkg.sv
// Shared defaults for the queued coalescing splitter and its comparator.
// Widths of lanes, addresses and offsets are derived locally in each module.
package coalesce_splitter_queued_pkg;

  localparam int unsigned DefNumRequests      = 4;
  localparam int unsigned DefAddressWidth     = 32;
  localparam int unsigned DefBlockIdxBits     = 4;
  localparam int unsigned DefCommonReqIdWidth = 1;
  localparam int unsigned DefQueueDepth       = 2;

endpackage

// File: rtl/coalesce_comparator.sv
// Coalesce comparator: picks the lowest-index pending lane as leader and
// reports every pending lane that falls in the leader's memory block.
//   pending : lanes still to be served
//   addr    : per-lane byte addresses, lane i at [i*AddressWidth +: AddressWidth]
//   member  : pending lanes sharing the leader's block (all zero if none pending)
//   block   : leader block address (zero if none pending)
//   offsets : per-lane byte offset within its block
module coalesce_comparator
  import coalesce_splitter_queued_pkg::*;
#(
  parameter int unsigned NumRequests  = DefNumRequests,
  parameter int unsigned AddressWidth = DefAddressWidth,
  parameter int unsigned BlockIdxBits = DefBlockIdxBits
) (
  input  logic [NumRequests-1:0]              pending,
  input  logic [NumRequests*AddressWidth-1:0] addr,
  output logic [NumRequests-1:0]              member,
  output logic [AddressWidth-BlockIdxBits-1:0] block,
  output logic [NumRequests*BlockIdxBits-1:0] offsets
);

  localparam int unsigned BlkW = AddressWidth - BlockIdxBits;

  logic found;

  always_comb begin
    found = 1'b0;
    block = '0;
    for (int unsigned i = 0; i < NumRequests; i++) begin
      if (pending[i] && !found) begin
        found = 1'b1;
        block = addr[i*AddressWidth + BlockIdxBits +: BlkW];
      end
    end
    member  = '0;
    offsets = '0;
    for (int unsigned i = 0; i < NumRequests; i++) begin
      member[i] = pending[i] && (addr[i*AddressWidth + BlockIdxBits +: BlkW] == block);
      offsets[i*BlockIdxBits +: BlockIdxBits] = addr[i*AddressWidth +: BlockIdxBits];
    end
  end

endmodule

// File: rtl/coalesce_splitter_queued.sv
// Queued coalescing splitter: buffers warp-wide requests in a ring FIFO and
// emits one registered block-aligned sub-request per cycle.
//   ready_o / valid_i / we_i / req_id_i / addr_valid_i / addr_i : request input
//   req_ready_i / req_valid_o / req_* : registered sub-request output
module coalesce_splitter_queued
  import coalesce_splitter_queued_pkg::*;
#(
  parameter  int unsigned NumRequests      = DefNumRequests,
  parameter  int unsigned AddressWidth     = DefAddressWidth,
  parameter  int unsigned BlockIdxBits     = DefBlockIdxBits,
  parameter  int unsigned CommonReqIdWidth = DefCommonReqIdWidth,
  parameter  int unsigned QueueDepth       = DefQueueDepth,
  localparam int unsigned SubReqIdWidth    = (NumRequests > 1) ? $clog2(NumRequests) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  output logic                                    ready_o,
  input  logic                                    valid_i,
  input  logic                                    we_i,
  input  logic [CommonReqIdWidth-1:0]             req_id_i,
  input  logic [NumRequests-1:0]                  addr_valid_i,
  input  logic [NumRequests*AddressWidth-1:0]     addr_i,
  input  logic                                    req_ready_i,
  output logic                                    req_valid_o,
  output logic [NumRequests-1:0]                  req_mask_o,
  output logic                                    req_we_o,
  output logic [CommonReqIdWidth-1:0]             req_com_id_o,
  output logic [SubReqIdWidth-1:0]                req_sub_id_o,
  output logic                                    req_last_o,
  output logic [AddressWidth-BlockIdxBits-1:0]    req_addr_o,
  output logic [NumRequests*BlockIdxBits-1:0]     req_offsets_o
);

  localparam int unsigned BlkW = AddressWidth - BlockIdxBits;
  localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW = $clog2(QueueDepth + 1);

  typedef logic [NumRequests-1:0]              lane_t;
  typedef logic [NumRequests*AddressWidth-1:0] addr_vec_t;
  typedef logic [NumRequests*BlockIdxBits-1:0] offs_vec_t;

  typedef struct packed {
    logic                        we;
    logic [CommonReqIdWidth-1:0] id;
    lane_t                       mask;
    addr_vec_t                   addr;
  } entry_t;

  typedef struct packed {
    lane_t                       mask;
    logic                        we;
    logic [CommonReqIdWidth-1:0] com_id;
    logic [SubReqIdWidth-1:0]    sub_id;
    logic                        last;
    logic [BlkW-1:0]             addr;
    offs_vec_t                   offsets;
  } out_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QueueDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- input FIFO ----------------
  entry_t          mem [QueueDepth];
  entry_t          entry_in;
  entry_t          head;
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;
  logic            fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count == CntW'(QueueDepth));
  assign fifo_empty = (count == '0);
  assign ready_o    = !fifo_full;
  assign push       = valid_i && !fifo_full;
  assign head       = mem[rd_ptr];

  always_comb begin
    entry_in      = '0;
    entry_in.we   = we_i;
    entry_in.id   = req_id_i;
    entry_in.mask = addr_valid_i;
    entry_in.addr = addr_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- working register ----------------
  logic                        wk_valid;
  lane_t                       wk_pending;
  addr_vec_t                   wk_addr;
  logic [CommonReqIdWidth-1:0] wk_id;
  logic                        wk_we;
  logic [SubReqIdWidth-1:0]    wk_sub;

  // When the working register is empty the comparator looks straight at the
  // FIFO head, so a fresh request reaches the output one cycle after insert.
  logic                        src_valid;
  lane_t                       src_pending;
  addr_vec_t                   src_addr;
  logic [CommonReqIdWidth-1:0] src_id;
  logic                        src_we;
  logic [SubReqIdWidth-1:0]    src_sub;

  always_comb begin
    src_valid = wk_valid || !fifo_empty;
    if (wk_valid) begin
      src_pending = wk_pending;
      src_addr    = wk_addr;
      src_id      = wk_id;
      src_we      = wk_we;
      src_sub     = wk_sub;
    end else begin
      src_pending = head.mask;
      src_addr    = head.addr;
      src_id      = head.id;
      src_we      = head.we;
      src_sub     = '0;
    end
  end

  lane_t           cmp_member;
  logic [BlkW-1:0] cmp_block;
  offs_vec_t       cmp_offsets;

  coalesce_comparator #(
    .NumRequests (NumRequests),
    .AddressWidth(AddressWidth),
    .BlockIdxBits(BlockIdxBits)
  ) u_cmp (
    .pending(src_pending),
    .addr   (src_addr),
    .member (cmp_member),
    .block  (cmp_block),
    .offsets(cmp_offsets)
  );

  lane_t remaining;
  logic  src_last, out_valid, out_load, wk_finish;

  assign remaining = src_pending & ~cmp_member;
  assign src_last  = (remaining == '0);
  assign out_load  = src_valid && (!out_valid || req_ready_i);
  assign wk_finish = wk_valid && out_load && src_last;
  assign pop       = !fifo_empty && (!wk_valid || wk_finish);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wk_valid   <= 1'b0;
      wk_pending <= '0;
      wk_addr    <= '0;
      wk_id      <= '0;
      wk_we      <= 1'b0;
      wk_sub     <= '0;
    end else if (wk_valid && !wk_finish) begin
      if (out_load) begin
        wk_pending <= remaining;
        wk_sub     <= wk_sub + 1'b1;
      end
    end else if (pop) begin
      wk_addr <= head.addr;
      wk_id   <= head.id;
      wk_we   <= head.we;
      if (!wk_valid && out_load) begin
        // head's first sub-request already went out through the bypass
        wk_valid   <= !src_last;
        wk_pending <= remaining;
        wk_sub     <= SubReqIdWidth'(1);
      end else begin
        wk_valid   <= 1'b1;
        wk_pending <= head.mask;
        wk_sub     <= '0;
      end
    end else begin
      wk_valid <= 1'b0;
    end
  end

  // ---------------- output register ----------------
  out_t out_next, out_q;

  always_comb begin
    out_next         = '0;
    out_next.mask    = cmp_member;
    out_next.we      = src_we;
    out_next.com_id  = src_id;
    out_next.sub_id  = src_sub;
    out_next.last    = src_last;
    out_next.addr    = cmp_block;
    out_next.offsets = cmp_offsets;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_q     <= out_next;
    end else if (req_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign req_valid_o   = out_valid;
  assign req_mask_o    = out_q.mask;
  assign req_we_o      = out_q.we;
  assign req_com_id_o  = out_q.com_id;
  assign req_sub_id_o  = out_q.sub_id;
  assign req_last_o    = out_q.last;
  assign req_addr_o    = out_q.addr;
  assign req_offsets_o = out_q.offsets;

endmodule
